// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths, ALU-op codes,
// sequencer states and the control bundle that a bubble clears.
package id_ex_stage_reg_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int RA_W_DEF      = 5;
  localparam int ALUOP_W_DEF   = 4;
  localparam int CNT_W_DEF     = 32;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [ALUOP_W_DEF-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic rw;
    logic mr;
    logic mw;
    logic m2r;
    logic asrc;
    logic is_halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Load-use hazard compare: a load in EX whose destination is read by the valid
// instruction in ID. x0 is never a hazard.
module id_ex_stage_reg_load_use_detector #(
  parameter int RA_W = 5
) (
  input  logic            i_ex_valid,
  input  logic            i_ex_mr,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_id_valid,
  input  logic            i_id_use_rs1,
  input  logic [RA_W-1:0] i_id_rs1,
  input  logic            i_id_use_rs2,
  input  logic [RA_W-1:0] i_id_rs2,
  output logic            o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_valid & i_ex_mr & (i_ex_rd != '0) & i_id_valid
                    & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use stall, flush bubbles, halt drain and perf counters.
// state | meaning: RUN normal flow; DRAIN halt moving through MEM/WB; HALTED core stopped until reset
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RA_W      = RA_W_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_id_valid,
  input  logic [XLEN-1:0]    i_id_pc,
  input  logic [RA_W-1:0]    i_id_rs1,
  input  logic [RA_W-1:0]    i_id_rs2,
  input  logic [RA_W-1:0]    i_id_rd,
  input  logic               i_id_use_rs1,
  input  logic               i_id_use_rs2,
  input  logic [XLEN-1:0]    i_id_rs1_data,
  input  logic [XLEN-1:0]    i_id_rs2_data,
  input  logic [XLEN-1:0]    i_id_imm,
  input  logic               i_id_ctrl_rw,
  input  logic               i_id_ctrl_mr,
  input  logic               i_id_ctrl_mw,
  input  logic               i_id_ctrl_m2r,
  input  logic               i_id_ctrl_asrc,
  input  logic [ALUOP_W-1:0] i_id_alu_op,
  input  logic               i_id_is_halt,
  input  logic               i_ex_flush,
  output logic               o_ex_valid,
  output logic [XLEN-1:0]    o_ex_pc,
  output logic [RA_W-1:0]    o_ex_rs1,
  output logic [RA_W-1:0]    o_ex_rs2,
  output logic [RA_W-1:0]    o_ex_rd,
  output logic               o_ex_use_rs1,
  output logic               o_ex_use_rs2,
  output logic [XLEN-1:0]    o_ex_rs1_data,
  output logic [XLEN-1:0]    o_ex_rs2_data,
  output logic [XLEN-1:0]    o_ex_imm,
  output logic               o_ex_ctrl_rw,
  output logic               o_ex_ctrl_mr,
  output logic               o_ex_ctrl_mw,
  output logic               o_ex_ctrl_m2r,
  output logic               o_ex_ctrl_asrc,
  output logic [ALUOP_W-1:0] o_ex_alu_op,
  output logic               o_ex_is_halt,
  output logic               o_stall_if_id,
  output logic               o_is_halted,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);

  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) + 1 : 1;

  ctrl_t               w_id_ctrl;
  ctrl_t               r_ex_ctrl;
  logic                r_ex_valid;
  logic [XLEN-1:0]     r_ex_pc;
  logic [RA_W-1:0]     r_ex_rs1;
  logic [RA_W-1:0]     r_ex_rs2;
  logic [RA_W-1:0]     r_ex_rd;
  logic                r_ex_use_rs1;
  logic                r_ex_use_rs2;
  logic [XLEN-1:0]     r_ex_rs1_data;
  logic [XLEN-1:0]     r_ex_rs2_data;
  logic [XLEN-1:0]     r_ex_imm;
  logic [ALUOP_W-1:0]  r_ex_alu_op;
  state_t              r_state;
  logic [DCNT_W-1:0]   r_drain_cnt;
  logic                r_is_halted;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_load_use;
  logic                w_run;
  logic                w_halt_in_ex;
  logic                w_bubble;
  logic                w_stall_evt;
  logic                w_flush_evt;

  assign w_id_ctrl = '{rw: i_id_ctrl_rw, mr: i_id_ctrl_mr, mw: i_id_ctrl_mw,
                       m2r: i_id_ctrl_m2r, asrc: i_id_ctrl_asrc, is_halt: i_id_is_halt};

  id_ex_stage_reg_load_use_detector #(.RA_W(RA_W)) u_load_use (
    .i_ex_valid  (r_ex_valid),
    .i_ex_mr     (r_ex_ctrl.mr),
    .i_ex_rd     (r_ex_rd),
    .i_id_valid  (i_id_valid),
    .i_id_use_rs1(i_id_use_rs1),
    .i_id_rs1    (i_id_rs1),
    .i_id_use_rs2(i_id_use_rs2),
    .i_id_rs2    (i_id_rs2),
    .o_load_use  (w_load_use)
  );

  // A halt sitting in EX already freezes fetch: everything behind it is dead.
  assign w_run         = (r_state == ST_RUN);
  assign w_halt_in_ex  = r_ex_valid & r_ex_ctrl.is_halt;
  assign w_bubble      = ~w_run | w_halt_in_ex | i_ex_flush | w_load_use;
  assign o_stall_if_id = (w_load_use & ~i_ex_flush) | ~w_run | w_halt_in_ex;
  assign w_stall_evt   = w_run & w_load_use & ~i_ex_flush;
  assign w_flush_evt   = w_run & i_ex_flush;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= CTRL_BUBBLE;
      r_ex_pc       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_use_rs1  <= 1'b0;
      r_ex_use_rs2  <= 1'b0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_alu_op   <= '0;
    end else if (w_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= CTRL_BUBBLE;
      r_ex_pc       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_use_rs1  <= 1'b0;
      r_ex_use_rs2  <= 1'b0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_alu_op   <= '0;
    end else begin
      r_ex_valid    <= i_id_valid;
      r_ex_ctrl     <= w_id_ctrl;
      r_ex_pc       <= i_id_pc;
      r_ex_rs1      <= i_id_rs1;
      r_ex_rs2      <= i_id_rs2;
      r_ex_rd       <= i_id_rd;
      r_ex_use_rs1  <= i_id_use_rs1;
      r_ex_use_rs2  <= i_id_use_rs2;
      r_ex_rs1_data <= i_id_rs1_data;
      r_ex_rs2_data <= i_id_rs2_data;
      r_ex_imm      <= i_id_imm;
      r_ex_alu_op   <= i_id_alu_op;
    end
  end

  // Drain counter reaches zero as the halt retires from WB; HALTED is entered on that edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_is_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_in_ex) begin
            if (DRAIN_CYC > 1) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DCNT_W'(DRAIN_CYC - 1);
            end else begin
              r_state     <= ST_HALTED;
              r_is_halted <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - DCNT_W'(1);
          if (r_drain_cnt == DCNT_W'(1)) begin
            r_state     <= ST_HALTED;
            r_is_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_is_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_pc        = r_ex_pc;
  assign o_ex_rs1       = r_ex_rs1;
  assign o_ex_rs2       = r_ex_rs2;
  assign o_ex_rd        = r_ex_rd;
  assign o_ex_use_rs1   = r_ex_use_rs1;
  assign o_ex_use_rs2   = r_ex_use_rs2;
  assign o_ex_rs1_data  = r_ex_rs1_data;
  assign o_ex_rs2_data  = r_ex_rs2_data;
  assign o_ex_imm       = r_ex_imm;
  assign o_ex_ctrl_rw   = r_ex_ctrl.rw;
  assign o_ex_ctrl_mr   = r_ex_ctrl.mr;
  assign o_ex_ctrl_mw   = r_ex_ctrl.mw;
  assign o_ex_ctrl_m2r  = r_ex_ctrl.m2r;
  assign o_ex_ctrl_asrc = r_ex_ctrl.asrc;
  assign o_ex_alu_op    = r_ex_alu_op;
  assign o_ex_is_halt   = r_ex_ctrl.is_halt;
  assign o_is_halted    = r_is_halted;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule
